// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-stage state encoding and default bus widths.
package cpu_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_DEC = 2'd2,
        DROP     = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads PC, issues one instruction-memory read at a time, and
// buffers the returned word in a single-entry IR handed to the decoder.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_inc,
    input  logic              redirect,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready
);

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic              load_ir, clear_ir;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            ir_valid <= 1'b0;
            ir       <= '0;
            ir_pc    <= '0;
        end else begin
            state  <= state_next;
            addr_q <= addr_next;
            if (load_ir) begin
                ir       <= mem_rdata;
                ir_pc    <= addr_q;
                ir_valid <= 1'b1;
            end else if (clear_ir) begin
                ir_valid <= 1'b0;
            end
        end
    end

    // pc already carries any redirect target, so every re-arm simply samples it.
    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        load_ir    = 1'b0;
        clear_ir   = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
                addr_next  = pc;
            end
            FETCH: begin
                if (mem_ack) begin
                    if (redirect) begin
                        addr_next = pc;
                    end else begin
                        load_ir    = 1'b1;
                        state_next = WAIT_DEC;
                    end
                end else if (redirect) begin
                    // Bus cannot be cancelled; let the stale read finish first.
                    state_next = DROP;
                end
            end
            WAIT_DEC: begin
                if (redirect || ir_ready) begin
                    clear_ir   = 1'b1;
                    addr_next  = pc;
                    state_next = FETCH;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    addr_next  = pc;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_req  = !reset && (state == FETCH || state == DROP);
    assign mem_addr = reset ? '0 : addr_q;
    assign pc_inc   = !reset && load_ir;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic against a transaction-level PC/memory/decoder model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = '0;
    logic        pc_inc;
    logic        redirect = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_inc(pc_inc), .redirect(redirect),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready)
    );

    int vectors = 0;
    int errors  = 0;

    // Environment / reference model state
    logic [15:0] pc_reg = '0;     // external program counter
    logic [15:0] exp_addr = '0;   // address the next delivered instruction must come from
    logic [15:0] req_addr = '0;   // address latched at start of current bus request
    logic [15:0] ld_addr = '0;
    bit          ld_pend = 0;     // an instruction was accepted last cycle
    bit          stale = 0;       // current bus request was overtaken by a redirect
    bit          after_rst = 0;
    int          wcnt = 0;
    int          lat = 0;
    int          fixed_lat = 0;

    // Outputs captured mid-cycle
    logic        c_req, c_inc, c_valid;
    logic [15:0] c_addr, c_ir, c_irpc;

    function automatic logic [15:0] word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    function automatic int new_lat();
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit rdy, input bit rd, input logic [15:0] tgt);
        bit ack, exp_inc;
        @(negedge clk);
        reset = rst;
        #1;
        ack       = !rst && mem_req && (wcnt >= lat);
        redirect  = rd && !rst;
        ir_ready  = rdy;
        pc        = redirect ? tgt : pc_reg;
        mem_ack   = ack;
        mem_rdata = ack ? word(mem_addr) : 16'($urandom);
        #1;
        c_req = mem_req; c_inc = pc_inc; c_valid = ir_valid;
        c_addr = mem_addr; c_ir = ir; c_irpc = ir_pc;

        if (rst) begin
            chk("rst_req", c_req, 0);
            chk("rst_inc", c_inc, 0);
            chk("rst_addr", c_addr, 0);
        end else begin
            if (after_rst) begin
                chk("post_rst_req", c_req, 0);
                chk("post_rst_valid", c_valid, 0);
                chk("post_rst_addr", c_addr, 0);
            end
            if (ld_pend) begin
                chk("ld_valid", c_valid, 1);
                chk("ld_irpc", c_irpc, ld_addr);
                chk("ld_ir", c_ir, word(ld_addr));
            end
            if (c_req && c_valid) chk("req_while_valid", 1, 0);
            if (c_req && wcnt > 0) chk("addr_stable", c_addr, req_addr);
            if (c_req && wcnt == 0 && !stale) chk("fetch_addr", c_addr, exp_addr);
            exp_inc = c_req && ack && !redirect && !stale;
            chk("pc_inc", c_inc, exp_inc);
            if (c_valid && rdy && !redirect) begin
                chk("consume_irpc", c_irpc, exp_addr);
                chk("consume_ir", c_ir, word(exp_addr));
            end
        end

        @(posedge clk);
        if (rst) begin
            pc_reg = '0; exp_addr = '0; wcnt = 0; stale = 0; ld_pend = 0;
            lat = new_lat(); after_rst = 1;
        end else begin
            after_rst = 0;
            pc_reg  = redirect ? tgt : pc_reg + 16'(c_inc);
            ld_pend = c_inc;
            ld_addr = c_addr;
            if (c_valid && rdy && !redirect) exp_addr = exp_addr + 16'd1;
            if (redirect) exp_addr = tgt;
            if (c_req) begin
                if (wcnt == 0) req_addr = c_addr;
                if (ack) begin
                    wcnt = 0; stale = 0; lat = new_lat();
                end else begin
                    wcnt++;
                    if (redirect) stale = 1;
                end
            end else begin
                wcnt = 0;
            end
        end
    endtask

    initial begin
        int n;
        bit seen;
        // Reset and zero-wait streaming
        fixed_lat = 0; lat = 0;
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);                 // IDLE
        step(0, 1, 0, 0);                 // FETCH 0 + ack
        chk("zw_req0", c_req, 1); chk("zw_addr0", c_addr, 0); chk("zw_inc0", c_inc, 1);
        step(0, 1, 0, 0);
        chk("zw_valid0", c_valid, 1); chk("zw_ir0", c_ir, 16'hA000); chk("zw_idle_req", c_req, 0);
        step(0, 1, 0, 0);
        chk("zw_addr1", c_addr, 1); chk("zw_inc1", c_inc, 1);
        step(0, 1, 0, 0);
        chk("zw_ir1", c_ir, 16'hA001); chk("zw_irpc1", c_irpc, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("zw_ir2", c_ir, 16'hA002); chk("zw_irpc2", c_irpc, 2);

        // Three wait states on address 3
        fixed_lat = 3; lat = 3;
        n = 0; seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 1, 0, 0);
            if (c_req) n++;
            if (c_inc) begin
                seen = 1;
                chk("ws_addr", c_addr, 3);
            end
        end
        chk("ws_seen_ack", seen, 1);
        chk("ws_req_cycles", n, 4);

        // Decoder stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            chk("stall_valid", c_valid, 1); chk("stall_ir", c_ir, 16'hA003);
            chk("stall_req", c_req, 0); chk("stall_inc", c_inc, 0);
        end
        fixed_lat = 0; lat = 0;
        step(0, 1, 0, 0);                 // consumed
        step(0, 1, 0, 0);
        chk("stall_next_addr", c_addr, 4); chk("stall_next_req", c_req, 1);

        // Redirect to 0x0040 while IR is waiting, decoder ready
        step(0, 1, 1, 16'h0040);
        chk("rd_wd_valid", c_valid, 1);
        step(0, 1, 0, 0);
        chk("rd_wd_addr", c_addr, 16'h0040);
        step(0, 0, 0, 0);
        chk("rd_wd_irpc", c_irpc, 16'h0040);

        // Redirect to 0x0080 while read of 0x0005 still has 2 wait cycles left
        fixed_lat = 3; lat = 3;
        step(0, 1, 1, 16'h0005);
        step(0, 1, 0, 0);
        chk("drop_addr5", c_addr, 5);
        step(0, 1, 1, 16'h0080);
        step(0, 1, 0, 0);
        chk("drop_req", c_req, 1); chk("drop_hold", c_addr, 5); chk("drop_inc_w", c_inc, 0);
        fixed_lat = 0;
        step(0, 1, 0, 0);
        chk("drop_ack_inc", c_inc, 0);
        step(0, 1, 0, 0);
        chk("drop_new_addr", c_addr, 16'h0080); chk("drop_new_inc", c_inc, 1);
        step(0, 1, 0, 0);
        chk("drop_irpc", c_irpc, 16'h0080); chk("drop_ir", c_ir, 16'hA080);

        // Reset in the middle of a wait-state read
        lat = 3;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("rst_refetch_addr", c_addr, 0); chk("rst_refetch_req", c_req, 1);

        // Randomized traffic
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage sitting directly downstream of the 16-bit program counter. It reads the current PC value, issues a read to instruction memory over a req/ack handshake, and latches the returned word into a single-entry instruction register (IR) presented to the decoder with a valid/ready handshake. It drives the PC's increment enable exactly once per accepted fetch, and flushes in-flight or buffered work when the PC is redirected by a branch load.

## Interface
- ADDR_W, 16, PC / memory address width
- DATA_W, 16, instruction word width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc  in  ADDR_W  current PC value; already reflects a redirect load in the same cycle
- pc_inc  out  1  PC increment enable; combinational
- redirect  in  1  one-cycle pulse coincident with a PC load (branch/jump)
- mem_req  out  1  instruction memory read request
- mem_addr  out  ADDR_W  read address, registered
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  read data
- ir_valid  out  1  IR holds an instruction for the decoder
- ir  out  DATA_W  instruction register
- ir_pc  out  ADDR_W  address the IR word was fetched from
- ir_ready  in  1  decoder accepts IR this cycle

## Operation
- States: IDLE, FETCH, WAIT_DEC, DROP.
- IDLE: mem_req=0. Next cycle -> FETCH, addr_q <= pc.
- FETCH: mem_req=1, mem_addr=addr_q, held stable until mem_ack.
  - mem_ack & !redirect: ir <= mem_rdata, ir_pc <= addr_q, ir_valid <= 1, pc_inc=1 this cycle; -> WAIT_DEC.
  - mem_ack & redirect: data discarded, pc_inc=0, addr_q <= pc (new target); stay FETCH.
  - !mem_ack & redirect: -> DROP (request must complete at old address).
- WAIT_DEC: mem_req=0, ir_valid=1.
  - redirect (dominates ir_ready): ir_valid <= 0, addr_q <= pc; -> FETCH.
  - ir_ready: ir_valid <= 0, addr_q <= pc (already incremented); -> FETCH.
- DROP: mem_req=1, mem_addr=old addr_q. On mem_ack: discard data, addr_q <= pc; -> FETCH. Further redirects in DROP need no extra action (target read from pc at exit).
- pc_inc is asserted only in FETCH with mem_ack & !redirect & !reset; never otherwise.
- ir/ir_pc retain value when ir_valid=0; only ir_valid is meaningful.
- At most one outstanding memory request; IR never overwritten while ir_valid=1.

## Timing
- Reset (synchronous, dominates all): state <= IDLE, addr_q <= 0, ir_valid <= 0, ir <= 0, ir_pc <= 0. While reset high and first cycle after: mem_req=0, pc_inc=0, mem_addr=0.
- Reset mid-request: request abandoned; memory must tolerate mem_req dropping without ack. A mem_ack in the reset cycle is ignored.
- Zero-wait memory (ack same cycle as req): cycle 0 IDLE; cycle 1 FETCH addr 0, ack; cycle 2 ir_valid=1, pc=1; with ir_ready high, cycle 3 FETCH addr 1. Peak throughput one instruction per 2 cycles.
- N wait states add N cycles in FETCH; mem_addr constant throughout.
- Fetch-to-IR latency: 1 cycle after mem_ack.
- Redirect-to-new-request: next cycle (FETCH/WAIT_DEC); after outstanding ack completes (DROP).

## Structure
- Shared package cpu_pkg: fetch state enum (IDLE, FETCH, WAIT_DEC, DROP), ADDR_W/DATA_W defaults.
- Single module, no sub-module; one state register, one next-state block, registered IR/addr datapath.

## Test plan
- Reset then zero-wait memory returning 16'hA000+addr, ir_ready=1 -> ir=A000,A001,A002 with ir_pc=0,1,2; pc_inc pulses once per fetch, ir_valid high every other cycle.
- Memory with 3 wait states -> mem_req high 4 cycles, mem_addr stable, single pc_inc pulse on ack cycle.
- ir_ready held 0 for 5 cycles after first fetch -> ir_valid stays 1, ir unchanged, mem_req=0, pc_inc=0; fetch of addr 1 starts cycle after ir_ready rises.
- redirect to 16'h0040 during WAIT_DEC with ir_ready=1 -> ir_valid drops, instruction not consumed, next mem_addr=0x0040.
- redirect to 16'h0080 while request to 0x0005 waiting 2 more cycles -> DROP, data at ack discarded, no pc_inc, next mem_addr=0x0080, ir_pc=0x0080.
- reset asserted mid-wait -> mem_req=0 next cycle, ir_valid=0, refetch from addr 0.
